arm_dp_alu_pipe: RTL and testbench
==================================

Name: arm_dp_alu_pipe

Overview:
- Registered, parametrised-width successor to the combinational data-processing ALU. Executes all 16 ARM data-processing opcodes with full ARM NZCV semantics.
- Owns the architectural flag register. ADC/SBC/RSC use that register's carry, so back-to-back flag dependencies resolve without external forwarding.
- Sits between operand fetch/barrel shifter and register-file writeback, joined by valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, operand/result width (>=8).
- SAT_EN, 0, 1 = arithmetic ops saturate to signed max/min on overflow; 0 = wrap (ARM).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- alu_control  in  4  opcode (AND=0 … MVN=15, ARM encoding).
- operand_a  in  DATA_W  Rn value.
- operand_b  in  DATA_W  shifter operand.
- shifter_carry  in  1  barrel-shifter carry-out, used as C for logical ops.
- set_flags  in  1  S bit.
- flags_load  in  1  MSR-style direct flag write.
- flags_in  in  4  NZCV value for flags_load.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts beat.
- result  out  DATA_W  registered result.
- result_writeback  out  1  beat writes Rd (0 for TST/TEQ/CMP/CMN).
- nzcv_writeback  out  1  beat updated the flag register.
- nzcv  out  4  current flag register {N,Z,C,V}.

Behaviour:
- Reset (async, active-high) forces: out_valid=0, result=0, result_writeback=0, nzcv_writeback=0, flag register=4'b0000.
  - Any in-flight beat is dropped.
  - in_ready=1 on the first edge after reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - An op is accepted on a clk edge where in_valid && in_ready.
  - Latency: 1 cycle from accept to out_valid.
  - While out_valid && !out_ready, result, result_writeback and nzcv_writeback hold stable.
  - Full throughput of one op per cycle when out_ready=1.
- Arithmetic (ADD, ADC, SUB, SBC, RSB, RSC, CMP, CMN):
  - Computed at DATA_W+1 bits.
  - C = carry-out for adds; C = NOT borrow for subtracts.
  - V = signed overflow.
  - ADC adds Cflag. SBC = a-b-!Cflag. RSC = b-a-!Cflag.
- Logical (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = shifter_carry, V unchanged.
  - MOV = b, MVN = ~b, BIC = a & ~b.
- N = result[DATA_W-1]; Z = (result == 0).
  - For compare/test ops these are taken from the internal unwritten result.
- SAT_EN=1: arithmetic writeback ops on overflow return 0x7F..F (positive overflow) or 0x80..0 (negative overflow).
  - V=1 and C is still the true carry.
  - N and Z follow the saturated value.
  - CMP/CMN flags are unaffected by saturation.
- Flag update: at the accept edge, if set_flags=1 or the op is TST/TEQ/CMP/CMN, the flag register loads the new NZCV, and nzcv_writeback=1 for that beat.
  - Otherwise flags hold and nzcv_writeback=0.
- The carry used by an accepted op is the flag-register value before the edge, which already includes the previous accepted op. No stall is needed for flag dependencies.
- flags_load on an edge overwrites the flag register with flags_in. This takes priority over an accepted op's update in the same cycle.
  - The accepted op still uses the pre-edge carry.
  - Its nzcv_writeback still reports 1 if it would have updated the flags.
- The flag register updates only on accept, never during stall. A stalled input does not modify flags.

Decomposition:
- Package arm_alu_pkg holds:
  - the 16 opcode localparams;
  - flag bit indices N=3, Z=2, C=1, V=0;
  - an is_test(opcode) function;
  - an is_arith(opcode) function.
- Sub-module arm_alu_core is purely combinational: (opcode, a, b, cflag, shifter_carry, SAT_EN) -> (result, nzcv_next, result_writeback).
- The top level owns the handshake, the output register and the flag register.

Test Plan:
- Wrap vs saturate: SAT_EN=0, ADD 0x7FFFFFFF+0x1, S=1 -> result 0x80000000, nzcv=4'b1001, result_writeback=1. SAT_EN=1, same op -> result 0x7FFFFFFF, nzcv=4'b0001.
- Carry chain back-to-back, out_ready=1: SUB 3-5 S=1 -> 0xFFFFFFFE, nzcv=4'b1000; next-cycle SBC 10-2 -> 7; then SUB 5-5 S=1 -> 0, nzcv=4'b0110; next ADC 1+1 -> 3.
- Compare without S: CMP a=1 b=1, set_flags=0 -> result_writeback=0, nzcv_writeback=1, nzcv=4'b0110. Then MOV b=0, set_flags=0 -> nzcv unchanged.
- Backpressure: out_ready=0 for 3 cycles while two ops are offered.
  - in_ready=0 after the first accept.
  - The first result holds stable.
  - The second op is accepted on the cycle out_ready=1 and appears one cycle later.
  - Flags change only at the two accept edges.
- Flag load race: flags_load=1 with flags_in=4'b0010 in the same cycle an ADC 0+0 S=1 is accepted with pre-edge C=0 -> result 0, nzcv=4'b0010 afterwards, nzcv_writeback=1.
- Reset mid-operation: assert reset with out_valid=1 and out_ready=0.
  - out_valid=0 and nzcv=0 immediately, without waiting for a clk edge.
  - After release, in_ready=1 and a fresh ADD 2+2 returns 4 with 1-cycle latency.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Opcodes, flag bit positions and opcode-class helpers for the ARM data-processing ALU.
package arm_alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_test(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_RSB) || (op == OP_ADD) || (op == OP_ADC) ||
           (op == OP_SBC) || (op == OP_RSC) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/arm_alu_core.sv
// Combinational ARM data-processing datapath: result, next NZCV and Rd-write flag.
// No state and no handshake; the pipeline wrapper owns timing and backpressure.
module arm_alu_core
  import arm_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit SAT_EN = 1'b0
) (
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cflag_i,
  input  logic              vflag_i,
  input  logic              shifter_carry_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        nzcv_o,
  output logic              result_writeback_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] add_x;
  logic [DATA_W-1:0] add_y;
  logic              add_cin;
  logic [DATA_W:0]   sum;
  logic              ovf;
  logic              arith;
  logic [DATA_W-1:0] logic_res;
  logic [DATA_W-1:0] res;

  // Every arithmetic op is folded into x + y + cin; subtracts invert one operand,
  // so the adder carry-out is directly the ARM "NOT borrow" C flag.
  always_comb begin
    add_x   = a_i;
    add_y   = b_i;
    add_cin = 1'b0;
    case (opcode_i)
      OP_SUB, OP_CMP: begin add_y = ~b_i; add_cin = 1'b1;    end
      OP_RSB:         begin add_x = b_i;  add_y = ~a_i; add_cin = 1'b1; end
      OP_ADC:         begin add_cin = cflag_i;               end
      OP_SBC:         begin add_y = ~b_i; add_cin = cflag_i; end
      OP_RSC:         begin add_x = b_i;  add_y = ~a_i; add_cin = cflag_i; end
      default:        ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
  assign ovf = (add_x[MSB] == add_y[MSB]) && (sum[MSB] != add_x[MSB]);

  always_comb begin
    logic_res = a_i & b_i;
    case (opcode_i)
      OP_EOR, OP_TEQ: logic_res = a_i ^ b_i;
      OP_ORR:         logic_res = a_i | b_i;
      OP_MOV:         logic_res = b_i;
      OP_BIC:         logic_res = a_i & ~b_i;
      OP_MVN:         logic_res = ~b_i;
      default:        ;
    endcase
  end

  assign arith              = is_arith(opcode_i);
  assign result_writeback_o = !is_test(opcode_i);

  // Overflow direction follows the sign of x: both addends positive means it ran off the top.
  always_comb begin
    res = arith ? sum[MSB:0] : logic_res;
    if (SAT_EN && arith && ovf && result_writeback_o)
      res = add_x[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  assign result_o = res;

  always_comb begin
    nzcv_o         = 4'b0000;
    nzcv_o[FLAG_N] = res[MSB];
    nzcv_o[FLAG_Z] = (res == '0);
    nzcv_o[FLAG_C] = arith ? sum[DATA_W] : shifter_carry_i;
    nzcv_o[FLAG_V] = arith ? ovf : vflag_i;
  end

endmodule

// File: rtl/arm_dp_alu_pipe.sv
// One-stage registered ARM ALU owning the NZCV register; result valid 1 cycle after accept.
// in_ready = !out_valid || out_ready; a stalled beat holds and flags never change while stalled.
module arm_dp_alu_pipe
  import arm_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit SAT_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              shifter_carry,
  input  logic              set_flags,
  input  logic              flags_load,
  input  logic [3:0]        flags_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_writeback,
  output logic              nzcv_writeback,
  output logic [3:0]        nzcv
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q;
  logic              res_wb_q;
  logic              nzcv_wb_q;
  logic [3:0]        flags_q, flags_d;

  logic              accept;
  logic              flag_upd;
  logic [DATA_W-1:0] core_result;
  logic [3:0]        core_nzcv;
  logic              core_wb;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign flag_upd = set_flags || is_test(alu_control);

  arm_alu_core #(
    .DATA_W (DATA_W),
    .SAT_EN (SAT_EN)
  ) u_core (
    .opcode_i           (alu_control),
    .a_i                (operand_a),
    .b_i                (operand_b),
    .cflag_i            (flags_q[FLAG_C]),
    .vflag_i            (flags_q[FLAG_V]),
    .shifter_carry_i    (shifter_carry),
    .result_o           (core_result),
    .nzcv_o             (core_nzcv),
    .result_writeback_o (core_wb)
  );

  // A direct flag write beats the accepted op's update on the same edge.
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)
      out_valid_d = 1'b1;
    else if (out_ready)
      out_valid_d = 1'b0;

    flags_d = flags_q;
    if (flags_load)
      flags_d = flags_in;
    else if (accept && flag_upd)
      flags_d = core_nzcv;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      res_wb_q    <= 1'b0;
      nzcv_wb_q   <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      if (accept) begin
        result_q  <= core_result;
        res_wb_q  <= core_wb;
        nzcv_wb_q <= flag_upd;
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign result           = result_q;
  assign result_writeback = res_wb_q;
  assign nzcv_writeback   = nzcv_wb_q;
  assign nzcv             = flags_q;

endmodule

// File: tb/tb_arm_dp_alu_pipe.sv
// Scoreboard bench: wrapping and saturating pipes share one random stimulus stream.
module tb_arm_dp_alu_pipe;
  import arm_alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, out_ready = 1'b0, shifter_carry = 1'b0;
  logic         set_flags = 1'b0, flags_load = 1'b0;
  logic [3:0]   alu_control = 4'd0, flags_in = 4'd0;
  logic [W-1:0] operand_a = '0, operand_b = '0;

  logic         in_ready0, in_ready1, ov0, ov1, rwb0, rwb1, nwb0, nwb1;
  logic [W-1:0] res0, res1;
  logic [3:0]   nz0, nz1;

  arm_dp_alu_pipe #(.DATA_W(W), .SAT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .shifter_carry(shifter_carry), .set_flags(set_flags), .flags_load(flags_load),
    .flags_in(flags_in), .out_valid(ov0), .out_ready(out_ready), .result(res0),
    .result_writeback(rwb0), .nzcv_writeback(nwb0), .nzcv(nz0));

  arm_dp_alu_pipe #(.DATA_W(W), .SAT_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .shifter_carry(shifter_carry), .set_flags(set_flags), .flags_load(flags_load),
    .flags_in(flags_in), .out_valid(ov1), .out_ready(out_ready), .result(res1),
    .result_writeback(rwb1), .nzcv_writeback(nwb1), .nzcv(nz1));

  typedef struct packed {
    logic [31:0] result;
    logic        rwb;
    logic        nwb;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         n_chk = 0;
  int         n_pass = 0;
  bit         mv = 1'b0;
  logic [3:0] f0 = 4'd0;
  logic [3:0] f1 = 4'd0;
  logic [31:0] edge_v [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // Reference model: signed/unsigned arithmetic on 64-bit integers, flags from range checks.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic sc, input logic s, input logic [3:0] f, input bit sat);
    exp_t e;
    longint ua, ub, sa, sb, ci, ur, sr;
    bit is_ar, is_add, c, v;
    logic [31:0] r;
    ua = longint'(a);  ub = longint'(b);
    sa = longint'($signed(a));  sb = longint'($signed(b));
    ci = longint'(f[1]);
    ur = 0;  sr = 0;  is_ar = 1'b1;  is_add = 1'b1;  c = 1'b0;  v = 1'b0;  r = '0;
    case (op)
      OP_ADD, OP_CMN: begin ur = ua + ub;      sr = sa + sb;      end
      OP_ADC:         begin ur = ua + ub + ci; sr = sa + sb + ci; end
      OP_SUB, OP_CMP: begin is_add = 1'b0; ur = ua - ub; sr = sa - sb; end
      OP_SBC:         begin is_add = 1'b0; ur = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); end
      OP_RSB:         begin is_add = 1'b0; ur = ub - ua; sr = sb - sa; end
      OP_RSC:         begin is_add = 1'b0; ur = ub - ua - (1 - ci); sr = sb - sa - (1 - ci); end
      default:        is_ar = 1'b0;
    endcase
    e.rwb = !(op == OP_TST || op == OP_TEQ || op == OP_CMP || op == OP_CMN);
    e.nwb = s || !e.rwb;
    if (is_ar) begin
      r = ur[31:0];
      c = is_add ? (ur > 64'sh00000000FFFFFFFF) : (ur >= 0);
      v = (sr > SMAX) || (sr < SMIN);
      if (sat && v && e.rwb) r = (sr > 0) ? 32'h7FFFFFFF : 32'h80000000;
    end else begin
      case (op)
        OP_AND, OP_TST: r = a & b;
        OP_EOR, OP_TEQ: r = a ^ b;
        OP_ORR:         r = a | b;
        OP_MOV:         r = b;
        OP_BIC:         r = a & ~b;
        default:        r = ~b;
      endcase
      c = sc;
      v = f[0];
    end
    e.result = r;
    e.nzcv   = {r[31], (r == 32'h0), c, v};
    return e;
  endfunction

  // One clock of stimulus; model state is advanced to what the coming edge should produce.
  task automatic drive(input bit iv, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit sc, input bit s, input bit fl, input logic [3:0] fin, input bit ordy);
    exp_t e;
    bit acc;
    @(posedge clk); #1;
    chk("nzcv0", {28'h0, nz0}, {28'h0, f0});
    chk("nzcv1", {28'h0, nz1}, {28'h0, f1});
    chk("out_valid0", {31'h0, ov0}, {31'h0, mv});
    chk("out_valid1", {31'h0, ov1}, {31'h0, mv});
    in_valid = iv; alu_control = op; operand_a = a; operand_b = b;
    shifter_carry = sc; set_flags = s; flags_load = fl; flags_in = fin; out_ready = ordy;
    #1;
    chk("in_ready0", {31'h0, in_ready0}, {31'h0, (!mv || ordy)});
    chk("in_ready1", {31'h0, in_ready1}, {31'h0, (!mv || ordy)});
    acc = iv && (!mv || ordy);
    if (acc) begin
      e = ref_op(op, a, b, sc, s, f0, 1'b0);
      q0.push_back(e);
      f0 = fl ? fin : (e.nwb ? e.nzcv : f0);
      e = ref_op(op, a, b, sc, s, f1, 1'b1);
      q1.push_back(e);
      f1 = fl ? fin : (e.nwb ? e.nzcv : f1);
      mv = 1'b1;
    end else begin
      if (ordy) mv = 1'b0;
      if (fl) begin f0 = fin; f1 = fin; end
    end
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, OP_AND, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, ordy);
  endtask

  task automatic mon(input int k, input logic ov, input logic [31:0] r, input logic rwb, input logic nwb);
    exp_t e;
    if (!ov) return;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_chk++;
      $display("FAIL beat%0d: output beat %h presented with none outstanding", k, r);
      return;
    end
    e = (k == 0) ? q0[0] : q1[0];
    chk($sformatf("result%0d", k), r, e.result);
    chk($sformatf("result_wb%0d", k), {31'h0, rwb}, {31'h0, e.rwb});
    chk($sformatf("nzcv_wb%0d", k), {31'h0, nwb}, {31'h0, e.nwb});
    if (out_ready) begin
      if (k == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, ov0, res0, rwb0, nwb0);
      mon(1, ov1, res1, rwb1, nwb1);
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, ov0}, 32'h0);
    chk("rst_result", res0, 32'h0);
    chk("rst_result_wb", {31'h0, rwb0}, 32'h0);
    chk("rst_nzcv_wb", {31'h0, nwb0}, 32'h0);
    chk("rst_nzcv", {28'h0, nz1}, 32'h0);
    @(negedge clk) reset = 1'b0;

    // Wrap vs saturate, then back-to-back carry chain.
    drive(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    drive(1'b1, OP_SUB, 32'd3,  32'd5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    drive(1'b1, OP_SBC, 32'd10, 32'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    drive(1'b1, OP_SUB, 32'd5,  32'd5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    drive(1'b1, OP_ADC, 32'd1,  32'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    // Compare without S, then a flagless MOV.
    drive(1'b1, OP_CMP, 32'd1,  32'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    drive(1'b1, OP_MOV, 32'd0,  32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    idle(1'b1);
    // Backpressure: three stalled cycles with two ops offered.
    drive(1'b1, OP_ADD, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    drive(1'b1, OP_SUB, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    drive(1'b1, OP_SUB, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    drive(1'b1, OP_SUB, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    idle(1'b1);
    // Flag-load race against an accepted ADC.
    drive(1'b0, OP_AND, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    drive(1'b1, OP_ADC, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      op = 4'($urandom % 16);
      a  = ($urandom % 4 == 0) ? edge_v[$urandom % 5] : $urandom;
      b  = ($urandom % 4 == 0) ? edge_v[$urandom % 5] : $urandom;
      drive(($urandom % 4) != 0, op, a, b, 1'($urandom % 2), 1'($urandom % 2),
            ($urandom % 16) == 0, 4'($urandom % 16), ($urandom % 10) < 7);
    end
    repeat (3) idle(1'b1);
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    // Reset while a beat is stalled at the output.
    drive(1'b1, OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'h0, ov0}, 32'h1);
    in_valid = 1'b0; out_ready = 1'b0; flags_load = 1'b0; reset = 1'b1;
    #1;
    chk("async_rst_valid0", {31'h0, ov0}, 32'h0);
    chk("async_rst_valid1", {31'h0, ov1}, 32'h0);
    chk("async_rst_nzcv0", {28'h0, nz0}, 32'h0);
    chk("async_rst_nzcv1", {28'h0, nz1}, 32'h0);
    chk("async_rst_result", res0, 32'h0);
    q0.delete(); q1.delete();
    mv = 1'b0; f0 = 4'd0; f1 = 4'd0;
    @(negedge clk) reset = 1'b0;
    drive(1'b1, OP_ADD, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (2) idle(1'b1);
    chk("final_q0", q0.size(), 32'd0);
    chk("final_q1", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
